// File: rtl/cla_add_seq_ctrl_pkg.sv
// Shared constants for the sequential carry-lookahead adder:
// FSM state codes, default operand/segment widths and the lookahead group size.
package cla_add_seq_ctrl_pkg;

    localparam int DEF_OP_WIDTH  = 256;
    localparam int DEF_SEG_WIDTH = 64;

    // Lookahead group width inside the segment adder; SEG_WIDTH must be a multiple of it.
    localparam int CLA_GROUP = 4;

    localparam logic [1:0] CLA_SEQ_IDLE = 2'd0;
    localparam logic [1:0] CLA_SEQ_RUN  = 2'd1;
    localparam logic [1:0] CLA_SEQ_DONE = 2'd2;

endpackage

// File: rtl/cla_add_seq_ctrl_if.sv
// Operand/result handshake bundle for cla_add_seq_ctrl.
// Optional macro CLA_SEQ_SUB_EN adds the sub_in select (A-B instead of A+B+c_in).
interface cla_add_seq_ctrl_if
    import cla_add_seq_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = DEF_OP_WIDTH
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] a_in;
    logic [OP_WIDTH-1:0] b_in;
    logic                c_in;
`ifdef CLA_SEQ_SUB_EN
    logic                sub_in;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [OP_WIDTH-1:0] sum;
    logic                c_out;

`ifdef CLA_SEQ_SUB_EN
    modport master (
        output in_valid, a_in, b_in, c_in, sub_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );
    modport slave (
        input  in_valid, a_in, b_in, c_in, sub_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
`else
    modport master (
        output in_valid, a_in, b_in, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out
    );
    modport slave (
        input  in_valid, a_in, b_in, c_in, out_ready,
        output in_ready, out_valid, sum, c_out
    );
`endif

endinterface

// File: rtl/cla_add_seq_ctrl_seg.sv
// cla_seg_add: combinational SEG_WIDTH-bit carry-lookahead adder.
// Built from 4-bit propagate/generate groups; each group resolves its internal
// carries and its group carry-out directly from the group input carry.
module cla_seg_add
    import cla_add_seq_ctrl_pkg::*;
#(
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 ci,
    output logic [SEG_WIDTH-1:0] s,
    output logic                 co
);
    localparam int NGRP = SEG_WIDTH / CLA_GROUP;

    // Group-wise lookahead: sum bits and carry out of the whole segment.
    always_comb begin
        logic [CLA_GROUP-1:0] p;
        logic [CLA_GROUP-1:0] g;
        logic [CLA_GROUP-1:0] c;
        logic                 gc;
        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        p  = '0;
        g  = '0;
        c  = '0;
        s  = '0;
        gc = ci;
        for (int k = 0; k < NGRP; k++) begin
            p    = a[CLA_GROUP*k +: CLA_GROUP] ^ b[CLA_GROUP*k +: CLA_GROUP];
            g    = a[CLA_GROUP*k +: CLA_GROUP] & b[CLA_GROUP*k +: CLA_GROUP];
            c[0] = gc;
            c[1] = g[0] | (p[0] & gc);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & gc);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & gc);
            s[CLA_GROUP*k +: CLA_GROUP] = p ^ c;
            gc   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | ((&p) & gc);
        end
        co = gc;
    end

endmodule

// File: rtl/cla_add_seq_ctrl.sv
// cla_add_seq_ctrl: adds two OP_WIDTH-bit operands over NSEG cycles with one
// SEG_WIDTH-bit lookahead segment adder, LSB segment first, carry held in carry_q.
// Optional macro CLA_SEQ_SUB_EN: sub_in=1 on accept computes A-B (c_out=1 means no borrow).
module cla_add_seq_ctrl
    import cla_add_seq_ctrl_pkg::*;
#(
    parameter int OP_WIDTH  = DEF_OP_WIDTH,
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    cla_add_seq_ctrl_if.slave bus
);
    localparam int              NSEG     = OP_WIDTH / SEG_WIDTH;
    localparam int              CNT_W    = $clog2(NSEG) + 1;
    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NSEG - 1);

    logic [1:0]                       state;
    logic [CNT_W-1:0]                 cnt;
    logic                             carry_q;
    logic                             c_out_q;
    logic [NSEG-1:0][SEG_WIDTH-1:0]   a_q;
    logic [NSEG-1:0][SEG_WIDTH-1:0]   b_q;
    logic [NSEG-1:0][SEG_WIDTH-1:0]   sum_q;
    logic [SEG_WIDTH-1:0]             seg_a;
    logic [SEG_WIDTH-1:0]             seg_b;
    logic [SEG_WIDTH-1:0]             seg_s;
    logic                             seg_co;
    logic [OP_WIDTH-1:0]              b_load;
    logic                             c_load;
    logic                             accept;
    logic                             last;

    assign bus.in_ready  = (state == CLA_SEQ_IDLE);
    assign bus.out_valid = (state == CLA_SEQ_DONE);
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;

    assign accept = bus.in_valid & (state == CLA_SEQ_IDLE);
    assign last   = (cnt == LAST_SEG);

`ifdef CLA_SEQ_SUB_EN
    // Subtract as A + ~B + 1; c_in has no effect when subtracting.
    assign b_load = bus.sub_in ? ~bus.b_in : bus.b_in;
    assign c_load = bus.sub_in | bus.c_in;
`else
    assign b_load = bus.b_in;
    assign c_load = bus.c_in;
`endif

    // Select the operand segment addressed by cnt.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (cnt == CNT_W'(i)) begin
                seg_a = a_q[i];
                seg_b = b_q[i];
            end
        end
    end

    cla_seg_add #(
        .SEG_WIDTH (SEG_WIDTH)
    ) u_seg_add (
        .a  (seg_a),
        .b  (seg_b),
        .ci (carry_q),
        .s  (seg_s),
        .co (seg_co)
    );

    // Operand capture on accept; held untouched through RUN and DONE.
    // NOTE: operand registers have no reset: they are only read in RUN, which is entered solely through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a_in;
            b_q <= b_load;
        end
    end

    // Sequencing FSM: one segment per RUN cycle, result held in DONE until taken.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLA_SEQ_IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                CLA_SEQ_IDLE: begin
                    if (accept) begin
                        state   <= CLA_SEQ_RUN;
                        cnt     <= '0;
                        carry_q <= c_load;
                    end
                end
                CLA_SEQ_RUN: begin
                    for (int i = 0; i < NSEG; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            sum_q[i] <= seg_s;
                        end
                    end
                    carry_q <= seg_co;
                    cnt     <= cnt + 1'b1;
                    if (last) begin
                        c_out_q <= seg_co;
                        state   <= CLA_SEQ_DONE;
                    end
                end
                CLA_SEQ_DONE: begin
                    if (bus.out_ready) begin
                        state <= CLA_SEQ_IDLE;
                    end
                end
                default: begin
                    state <= CLA_SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_add_seq_ctrl.sv
// Scoreboard bench for cla_add_seq_ctrl: a 256/64 instance (NSEG=4) and a 64/64
// instance (NSEG=1). Drivers push expected results; per-instance monitors pop and
// compare sum, c_out and latency when out_valid rises.
// Define CLA_SEQ_SUB_EN to also exercise subtraction.
module tb_cla_add_seq_ctrl;
    import cla_add_seq_ctrl_pkg::*;

    typedef struct {
        string        tag;
        logic [255:0] sum;
        logic         c_out;
        int           accept;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    logic ov0_d = 1'b0;
    logic ov1_d = 1'b0;

    cla_add_seq_ctrl_if #(.OP_WIDTH(256)) bus0 ();
    cla_add_seq_ctrl_if #(.OP_WIDTH(64))  bus1 ();

    cla_add_seq_ctrl #(.OP_WIDTH(256), .SEG_WIDTH(64)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    cla_add_seq_ctrl #(.OP_WIDTH(64), .SEG_WIDTH(64)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the NSEG=4 instance.
    always @(negedge clk) begin
        if (rst) begin
            ov0_d = 1'b0;
        end else begin
            if (bus0.out_valid && !ov0_d) begin
                if (q0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result0: got sum %h with no pending operation", bus0.sum);
                end else begin
                    e0 = q0.pop_front();
                    check({e0.tag, "_sum"}, bus0.sum, e0.sum);
                    check({e0.tag, "_cout"}, 256'(bus0.c_out), 256'(e0.c_out));
                    check({e0.tag, "_latency"}, 256'(cyc - e0.accept), 256'd4);
                end
            end
            ov0_d = bus0.out_valid;
        end
    end

    // Monitor for the NSEG=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            ov1_d = 1'b0;
        end else begin
            if (bus1.out_valid && !ov1_d) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result1: got sum %h with no pending operation", bus1.sum);
                end else begin
                    e1 = q1.pop_front();
                    check({e1.tag, "_sum"}, 256'(bus1.sum), e1.sum);
                    check({e1.tag, "_cout"}, 256'(bus1.c_out), 256'(e1.c_out));
                    check({e1.tag, "_latency"}, 256'(cyc - e1.accept), 256'd1);
                end
            end
            ov1_d = bus1.out_valid;
        end
    end

    task automatic send0(input string tag, input logic [255:0] a, input logic [255:0] b,
                         input logic c, input logic sub,
                         input logic [255:0] es, input logic ec);
        int waited = 0;
        @(negedge clk);
        bus0.a_in     = a;
        bus0.b_in     = b;
        bus0.c_in     = c;
`ifdef CLA_SEQ_SUB_EN
        bus0.sub_in   = sub;
`endif
        bus0.in_valid = 1'b1;
        while (!bus0.in_ready) begin
            if (waited == 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_accept_timeout: in_ready stayed %b, required 1", tag, bus0.in_ready);
                bus0.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        q0.push_back('{tag: tag, sum: es, c_out: ec, accept: cyc});
        if (sub) begin end
    endtask

    task automatic send1(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic [63:0] es, input logic ec);
        int waited = 0;
        @(negedge clk);
        bus1.a_in     = a;
        bus1.b_in     = b;
        bus1.c_in     = c;
        bus1.in_valid = 1'b1;
        while (!bus1.in_ready) begin
            if (waited == 50) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_accept_timeout: in_ready stayed %b, required 1", tag, bus1.in_ready);
                bus1.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        q1.push_back('{tag: tag, sum: 256'(es), c_out: ec, accept: cyc});
    endtask

    // Wait until both scoreboards are empty and both results have been taken.
    task automatic drain(input string tag);
        int waited = 0;
        while (q0.size() != 0 || q1.size() != 0 || bus0.out_valid || bus1.out_valid) begin
            if (waited == 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s_drain_timeout: pending %0d/%0d results, required 0/0",
                         tag, q0.size(), q1.size());
                return;
            end
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] ones;
        logic [255:0] low64;
        logic [255:0] low128;
        logic [255:0] msb;
        int           waited;
        ones   = '1;
        low64  = {192'd0, {64{1'b1}}};
        low128 = {128'd0, {128{1'b1}}};
        msb    = 256'd1 << 255;

        bus0.in_valid  = 1'b0;
        bus0.a_in      = '0;
        bus0.b_in      = '0;
        bus0.c_in      = 1'b0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.a_in      = '0;
        bus1.b_in      = '0;
        bus1.c_in      = 1'b0;
        bus1.out_ready = 1'b1;
`ifdef CLA_SEQ_SUB_EN
        bus0.sub_in    = 1'b0;
        bus1.sub_in    = 1'b0;
`endif

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_in_ready0", 256'(bus0.in_ready), 256'd1);
        check("rst_out_valid0", 256'(bus0.out_valid), 256'd0);
        check("rst_sum0", bus0.sum, 256'd0);
        check("rst_cout0", 256'(bus0.c_out), 256'd0);
        check("rst_in_ready1", 256'(bus1.in_ready), 256'd1);
        check("rst_sum1", 256'(bus1.sum), 256'd0);
        rst = 1'b0;

        // Reset in the 2nd RUN cycle aborts the operation.
        @(negedge clk);
        bus0.a_in     = 256'd3;
        bus0.b_in     = 256'd4;
        bus0.c_in     = 1'b0;
        bus0.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check("abort_busy_in_ready", 256'(bus0.in_ready), 256'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", 256'(bus0.out_valid), 256'd0);
        check("abort_sum", bus0.sum, 256'd0);
        check("abort_cout", 256'(bus0.c_out), 256'd0);
        check("abort_in_ready", 256'(bus0.in_ready), 256'd1);
        repeat (6) @(negedge clk);

        // Carry from segment 0 into segment 1.
        send0("seg_carry", 256'd1, low64, 1'b0, 1'b0, 256'd1 << 64, 1'b0);
        drain("seg_carry");
        // Carry ripples through every segment.
        send0("all_ones", ones, ones, 1'b1, 1'b0, ones, 1'b1);
        drain("all_ones");
        // Overflow wraps; overflow bit lands in c_out.
        send0("overflow", msb, msb, 1'b0, 1'b0, 256'd0, 1'b1);
        drain("overflow");
        // Small operands with carry-in.
        send0("small_cin", 256'h1234, 256'h1111, 1'b1, 1'b0, 256'h2346, 1'b0);
        drain("small_cin");
        // Carry-in propagates across two segments into segment 2.
        send0("cin_ripple", low128, 256'd0, 1'b1, 1'b0, 256'd1 << 128, 1'b0);
        drain("cin_ripple");

        // Backpressure: result held for 10 cycles, new operands ignored.
        bus0.out_ready = 1'b0;
        send0("bp", 256'd3, 256'd4, 1'b0, 1'b0, 256'd7, 1'b0);
        waited = 0;
        while (!bus0.out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 10; i++) begin
            bus0.a_in     = ones;
            bus0.b_in     = 256'd1;
            bus0.in_valid = 1'b1;
            check("bp_out_valid", 256'(bus0.out_valid), 256'd1);
            check("bp_sum", bus0.sum, 256'd7);
            check("bp_cout", 256'(bus0.c_out), 256'd0);
            check("bp_in_ready", 256'(bus0.in_ready), 256'd0);
            @(negedge clk);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", 256'(bus0.out_valid), 256'd0);
        check("bp_release_in_ready", 256'(bus0.in_ready), 256'd1);
        repeat (8) @(negedge clk);
        drain("bp");

        // Single-segment instance: latency 1.
        send1("nseg1_ovf", 64'd1 << 63, 64'd1 << 63, 1'b0, 64'd0, 1'b1);
        drain("nseg1_ovf");
        send1("nseg1_small", 64'd5, 64'd7, 1'b1, 64'd13, 1'b0);
        drain("nseg1_small");

`ifdef CLA_SEQ_SUB_EN
        // Subtraction: borrow clears c_out; c_in has no effect.
        send0("sub_neg", 256'd5, 256'd7, 1'b0, 1'b1, {{255{1'b1}}, 1'b0}, 1'b0);
        drain("sub_neg");
        send0("sub_pos", 256'd7, 256'd5, 1'b1, 1'b1, 256'd2, 1'b1);
        drain("sub_pos");
        bus0.sub_in = 1'b0;
`endif

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
